// File: rtl/synapse_current_if.sv
// Spike/weight-write/current bundle between a spike source and synapse_current.
// The master side drives spikes and weight writes; the slave side returns the
// postsynaptic current, the one-cycle saturation flag and the spike count.
interface synapse_current_if #(
  parameter int NUM_IN = 4
) ();
  logic              en;
  logic [NUM_IN-1:0] spike_in;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        current;
  logic              sat;
  logic [15:0]       spike_cnt;

  modport master (
    output en, spike_in, wr_en, wr_addr, wr_data,
    input  current, sat, spike_cnt
  );

  modport slave (
    input  en, spike_in, wr_en, wr_addr, wr_data,
    output current, sat, spike_cnt
  );
endinterface

// File: rtl/synapse_current.sv
// synapse_current: leaky, saturating current accumulator driven by weighted
// presynaptic spikes. Each weight is programmed through a synchronous write
// port, and a spike always uses the weight that was stored before that cycle.
// Optional build macro SYNAPSE_INHIBIT_EN: the upper half of the inputs
// (index >= NUM_IN/2) subtract their weight, and the result is clamped to 0..255.
module synapse_current #(
  parameter int NUM_IN      = 4,
  parameter int DECAY_SHIFT = 2,
  parameter int WEIGHT_INIT = 32
) (
  input logic            clk,
  input logic            rst,
  synapse_current_if.slave bus
);

  logic [7:0]  r_weight [NUM_IN];
  logic [7:0]  r_current;
  logic        r_sat;
  logic [15:0] r_spike_cnt;

  logic [10:0] w_exc;
  logic [3:0]  w_pop;
  logic [7:0]  w_leak_raw;
  logic [7:0]  w_leak;
  logic [7:0]  w_cur_nxt;
  logic        w_sat_nxt;
  logic [16:0] w_cnt_sum;
  logic [15:0] w_cnt_nxt;
`ifdef SYNAPSE_INHIBIT_EN
  logic [10:0]        w_inh;
  logic signed [12:0] w_acc_s;
`else
  logic [11:0]        w_acc;
`endif

  // Weighted spike sums and spike popcount for the current cycle.
  always_comb begin
    w_exc = '0;
    w_pop = '0;
`ifdef SYNAPSE_INHIBIT_EN
    w_inh = '0;
`endif
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.spike_in[i]) begin
        w_pop = w_pop + 4'd1;
`ifdef SYNAPSE_INHIBIT_EN
        if (i >= NUM_IN / 2) w_inh = w_inh + {3'b000, r_weight[i]};
        else                 w_exc = w_exc + {3'b000, r_weight[i]};
`else
        w_exc = w_exc + {3'b000, r_weight[i]};
`endif
      end
    end
  end

  // Leak, accumulate and clamp; the leak never drops below 1 while current is nonzero.
  always_comb begin
    w_leak_raw = r_current >> DECAY_SHIFT;
    w_leak     = ((w_leak_raw == 8'd0) && (r_current != 8'd0)) ? 8'd1 : w_leak_raw;
    w_cur_nxt  = '0;
    w_sat_nxt  = 1'b0;
`ifdef SYNAPSE_INHIBIT_EN
    w_acc_s = $signed({5'b0, r_current}) - $signed({5'b0, w_leak})
            + $signed({2'b0, w_exc}) - $signed({2'b0, w_inh});
    if (w_acc_s < 13'sd0) begin
      w_cur_nxt = 8'd0;
      w_sat_nxt = 1'b1;
    end else if (w_acc_s > 13'sd255) begin
      w_cur_nxt = 8'd255;
      w_sat_nxt = 1'b1;
    end else begin
      w_cur_nxt = w_acc_s[7:0];
    end
`else
    w_acc = {4'b0, r_current} - {4'b0, w_leak} + {1'b0, w_exc};
    if (w_acc > 12'd255) begin
      w_cur_nxt = 8'd255;
      w_sat_nxt = 1'b1;
    end else begin
      w_cur_nxt = w_acc[7:0];
    end
`endif
    w_cnt_sum = {1'b0, r_spike_cnt} + {13'b0, w_pop};
    w_cnt_nxt = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
  end

  // Weight registers; an address outside 0..NUM_IN-1 matches no entry and is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) r_weight[i] <= 8'(WEIGHT_INIT);
    end else if (bus.wr_en) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.wr_addr == 3'(i)) r_weight[i] <= bus.wr_data;
      end
    end
  end

  // Accumulator, saturation flag and spike counter; en=0 holds state and clears sat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_current   <= '0;
      r_sat       <= 1'b0;
      r_spike_cnt <= '0;
    end else if (bus.en) begin
      r_current   <= w_cur_nxt;
      r_sat       <= w_sat_nxt;
      r_spike_cnt <= w_cnt_nxt;
    end else begin
      r_sat       <= 1'b0;
    end
  end

  assign bus.current   = r_current;
  assign bus.sat       = r_sat;
  assign bus.spike_cnt = r_spike_cnt;

endmodule

// File: tb/tb_synapse_current.sv
// Directed bench for synapse_current (NUM_IN=4, DECAY_SHIFT=2, WEIGHT_INIT=32).
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_synapse_current;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  synapse_current_if #(.NUM_IN(4)) bus ();

  synapse_current #(.NUM_IN(4), .DECAY_SHIFT(2), .WEIGHT_INIT(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef SYNAPSE_INHIBIT_EN
  localparam bit INH = 1'b1;
`else
  localparam bit INH = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  int dec_seq [15] = '{32, 24, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] sp);
    bus.spike_in = sp;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'b0000);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    cyc(4'b0000);
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    logic [3:0] sp;
    bus.en       = 1'b0;
    bus.spike_in = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_current", bus.current, 0);
    chk("rst_sat", bus.sat, 0);
    chk("rst_cnt", bus.spike_cnt, 0);
    rst    = 1'b0;
    bus.en = 1'b1;
    @(negedge clk);

    // single spike on input 0, then decay to zero
    cyc(4'b0001);
    chk("decay_0", bus.current, dec_seq[0]);
    chk("decay_sat", bus.sat, 0);
    for (int k = 1; k < 15; k++) begin
      cyc(4'b0000);
      chk($sformatf("decay_%0d", k), bus.current, dec_seq[k]);
    end
    chk("decay_cnt", bus.spike_cnt, 1);

    // write to w[1] in the same cycle as a spike on input 1
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd1;
    bus.wr_data = 8'd80;
    cyc(4'b0010);
    bus.wr_en   = 1'b0;
    chk("coll_old_w", bus.current, 32);
    cyc(4'b0010);
    chk("coll_new_w", bus.current, 104);
    chk("coll_cnt", bus.spike_cnt, 3);
    idle(40);
    chk("coll_decayed", bus.current, 0);

    // saturation with all weights at 100
    for (int i = 0; i < 4; i++) wr(3'(i), 8'd100);
    cyc(4'b1111);
    chk("sat_current", bus.current, INH ? 0 : 255);
    chk("sat_flag", bus.sat, INH ? 0 : 1);
    cyc(4'b0000);
    chk("sat_next_current", bus.current, INH ? 0 : 192);
    chk("sat_next_flag", bus.sat, 0);
    chk("sat_cnt", bus.spike_cnt, 7);
    idle(40);

    // out-of-range write must not touch any weight
    wr(3'd5, 8'd7);
    wr(3'd4, 8'd9);
    cyc(4'b0010);
    chk("badaddr_w1", bus.current, 100);
    chk("badaddr_cnt", bus.spike_cnt, 8);

    // en=0: spikes dropped, state held
    bus.en = 1'b0;
    repeat (5) cyc(4'b1111);
    chk("hold_current", bus.current, 100);
    chk("hold_cnt", bus.spike_cnt, 8);
    chk("hold_sat", bus.sat, 0);

    // saturate, then en=0 clears sat but holds current
    bus.en = 1'b1;
    cyc(4'b1111);
    chk("sat2_current", bus.current, INH ? 75 : 255);
    chk("sat2_flag", bus.sat, INH ? 0 : 1);
    bus.en = 1'b0;
    cyc(4'b0000);
    chk("en0_sat_clr", bus.sat, 0);
    chk("en0_current", bus.current, INH ? 75 : 255);
    chk("en0_cnt", bus.spike_cnt, 12);
    bus.en = 1'b1;
    idle(40);

    // asynchronous reset mid-run with current=150
    wr(3'd0, 8'd150);
    cyc(4'b0001);
    chk("pre_rst_current", bus.current, 150);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_current", bus.current, 0);
    chk("async_rst_sat", bus.sat, 0);
    chk("async_rst_cnt", bus.spike_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // counting: 0011 for 3 cycles
    repeat (3) cyc(4'b0011);
    chk("cnt_6", bus.spike_cnt, 6);
    chk("cnt_current", bus.current, 148);
    idle(40);
    chk("cnt_decayed", bus.current, 0);

    // single-spike probes: every weight back to 32 after reset
    for (int i = 0; i < 4; i++) begin
      sp = 4'(1 << i);
      cyc(sp);
      chk($sformatf("probe_w%0d", i), bus.current, (INH && i >= 2) ? 0 : 32);
      chk($sformatf("probe_sat%0d", i), bus.sat, (INH && i >= 2) ? 1 : 0);
      idle(20);
    end
    chk("probe_cnt", bus.spike_cnt, 10);

`ifdef SYNAPSE_INHIBIT_EN
    // inhibitory spike drives current below zero
    wr(3'd0, 8'd10);
    wr(3'd2, 8'd50);
    cyc(4'b0001);
    chk("inh_pre", bus.current, 10);
    cyc(4'b0100);
    chk("inh_current", bus.current, 0);
    chk("inh_sat", bus.sat, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
